// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader for the single-cycle core's instruction memory. A byte
//   stream (UART RX side) carries a 4-byte little-endian word count N followed
//   by N little-endian program words. The words are written to consecutive
//   imem words starting at BASE_ADDR while the core is held in reset. In RUN
//   the imem address port belongs to the core (PC_out).
//
//   Optional feature: define CHECKSUM_EN to expect one extra 4-byte word after
//   the program, which must equal the XOR of all N program words.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   start         : 1-cycle (re)load request, honoured in RUN and ERROR
//   rx_valid/data : byte stream, one byte per valid cycle
//   PC_out        : core fetch address, drives imem_addr in RUN
//   imem_addr     : loader word address or PC_out
//   imem_wr_en    : 1-cycle write strobe, imem_wr_data is the word
//   cpu_reset     : holds the core in reset during load/error
//   busy          : high in HDR, LOAD, CHK
//   done          : 1-cycle pulse on successful load
//   error         : high while in ERROR
module imem_boot_loader #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic [31:0] PC_out,
   output logic [31:0] imem_addr,
   output logic        imem_wr_en,
   output logic [31:0] imem_wr_data,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int AW = $clog2(DEPTH_WORDS) + 1;

   typedef enum logic [2:0] {
      S_RUN,
      S_HDR,
      S_LOAD,
`ifdef CHECKSUM_EN
      S_CHK,
`endif
      S_ERROR
   } state_t;

   state_t         state_q;
   logic [1:0]     byte_cnt_q;
   logic [23:0]    buf_q;        // bytes 0..2 of the word being assembled
   logic [AW-1:0]  word_idx_q;
   logic [AW-1:0]  n_q;
   logic           wr_en_q;
   logic [31:0]    wr_data_q;
   logic           cpu_rst_q;
   logic           done_q;
   logic           err_q;
`ifdef CHECKSUM_EN
   logic [31:0]    xor_q;
`endif

   // Complete word when the current byte is the 4th one.
   logic [31:0]    word_d;
   logic [AW-1:0]  word_idx_d;
   assign word_d     = {rx_data, buf_q};
   assign word_idx_d = AW'(word_idx_q + 1'b1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_RUN;
         byte_cnt_q <= '0;
         buf_q      <= '0;
         word_idx_q <= '0;
         n_q        <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         cpu_rst_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         done_q  <= 1'b0;
         wr_en_q <= 1'b0;
         case (state_q)
            S_RUN, S_ERROR: begin
               // rx_valid is ignored here; a byte coincident with start is dropped
               if (start) begin
                  state_q    <= S_HDR;
                  byte_cnt_q <= '0;
                  word_idx_q <= '0;
                  cpu_rst_q  <= 1'b1;
                  err_q      <= 1'b0;
`ifdef CHECKSUM_EN
                  xor_q      <= '0;
`endif
               end
            end
            S_HDR: begin
               if (rx_valid) begin
                  if (byte_cnt_q == 2'd3) begin
                     byte_cnt_q <= '0;
                     if (word_d == 32'd0) begin
                        state_q   <= S_RUN;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                     end else if (word_d > 32'(DEPTH_WORDS)) begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                     end else begin
                        state_q    <= S_LOAD;
                        n_q        <= word_d[AW-1:0];
                        word_idx_q <= '0;
                     end
                  end else begin
                     buf_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
            end
            S_LOAD: begin
               // Bytes of the next word may arrive during the write cycle.
               if (rx_valid) begin
                  if (byte_cnt_q == 2'd3) begin
                     byte_cnt_q <= '0;
                     wr_en_q    <= 1'b1;
                     wr_data_q  <= word_d;
                  end else begin
                     buf_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
               // Address advances once the write cycle has been presented.
               if (wr_en_q) begin
                  word_idx_q <= word_idx_d;
`ifdef CHECKSUM_EN
                  xor_q <= xor_q ^ wr_data_q;
                  if (word_idx_d == n_q)
                     state_q <= S_CHK;
`else
                  if (word_idx_d == n_q) begin
                     state_q    <= S_RUN;
                     done_q     <= 1'b1;
                     cpu_rst_q  <= 1'b0;
                     byte_cnt_q <= '0;
                  end
`endif
               end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
               if (rx_valid) begin
                  if (byte_cnt_q == 2'd3) begin
                     byte_cnt_q <= '0;
                     if (word_d == xor_q) begin
                        state_q   <= S_RUN;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                     end else begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                     end
                  end else begin
                     buf_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
                     byte_cnt_q <= byte_cnt_q + 2'd1;
                  end
               end
            end
`endif
            default: state_q <= S_RUN;
         endcase
      end
   end

   assign imem_addr    = (state_q == S_RUN) ? PC_out
                       : BASE_ADDR + {{(30-AW){1'b0}}, word_idx_q, 2'b00};
   assign imem_wr_en   = wr_en_q;
   assign imem_wr_data = wr_data_q;
   assign cpu_reset    = cpu_rst_q;
   assign done         = done_q;
   assign error        = err_q;
`ifdef CHECKSUM_EN
   assign busy = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
`else
   assign busy = (state_q == S_HDR) || (state_q == S_LOAD);
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Directed-vector bench for imem_boot_loader (DEPTH_WORDS=256, BASE_ADDR=0).
//   Inputs change 1ns after a rising edge; outputs are sampled there too, so a
//   value read after tick() is the one for the cycle following that edge.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [31:0] PC_out;
   logic [31:0] imem_addr;
   logic        imem_wr_en;
   logic [31:0] imem_wr_data;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   int n_vec = 0;
   int n_bad = 0;

   imem_boot_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
      .rx_data(rx_data), .PC_out(PC_out), .imem_addr(imem_addr),
      .imem_wr_en(imem_wr_en), .imem_wr_data(imem_wr_data),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      PC_out = 32'h4;
      tick(); tick();
      reset = 1'b0;

      // 1: reset state, core owns the address port
      chk("rst_addr", imem_addr, 32'h4);
      chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
      chk("rst_wr_en", {31'b0, imem_wr_en}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done_err", {30'b0, done, error}, 32'd0);
      chk("rst_wr_data", imem_wr_data, 32'd0);

      // 2: two-word program
      PC_out = 32'h100;
      pulse_start();
      chk("t2_hdr_busy", {30'b0, busy, cpu_reset}, 32'd3);
      chk("t2_hdr_addr", imem_addr, 32'h0);
      send_word(32'd2);
      chk("t2_hdr_nowr", {31'b0, imem_wr_en}, 32'd0);
      send_word(32'h0000_0013);
      chk("t2_w0_en", {31'b0, imem_wr_en}, 32'd1);
      chk("t2_w0_data", imem_wr_data, 32'h0000_0013);
      chk("t2_w0_addr", imem_addr, 32'h0);
      send_byte(8'h93);               // arrives during the write cycle
      chk("t2_w1_idle", {31'b0, imem_wr_en}, 32'd0);
      chk("t2_w1_addr_pre", imem_addr, 32'h4);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      chk("t2_w1_en", {31'b0, imem_wr_en}, 32'd1);
      chk("t2_w1_data", imem_wr_data, 32'h0010_0093);
      chk("t2_w1_addr", imem_addr, 32'h4);
      tick();
`ifdef CHECKSUM_EN
      chk("t6_chk_busy", {30'b0, busy, done}, 32'd2);
      send_word(32'h0010_0080);
`endif
      chk("t2_done", {31'b0, done}, 32'd1);
      chk("t2_cpu_reset", {31'b0, cpu_reset}, 32'd0);
      chk("t2_run_addr", imem_addr, 32'h100);
      chk("t2_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("t2_done_pulse", {31'b0, done}, 32'd0);

      // 3: empty program
      pulse_start();
      send_word(32'd0);
      chk("t3_done", {31'b0, done}, 32'd1);
      chk("t3_run", {30'b0, busy, cpu_reset}, 32'd0);
      chk("t3_nowr", {31'b0, imem_wr_en}, 32'd0);

      // 4: oversize header -> ERROR, bytes ignored, start recovers
      tick();
      pulse_start();
      send_word(32'd257);
      chk("t4_error", {30'b0, error, cpu_reset}, 32'd3);
      chk("t4_busy", {31'b0, busy}, 32'd0);
      send_byte(8'h55);
      chk("t4_err_hold", {30'b0, error, busy}, 32'd2);
      pulse_start();
      chk("t4_restart", {29'b0, error, busy, cpu_reset}, 32'd3);

      // 5: N=2, word 0 with rx gaps, reset after 2 bytes of word 1
      send_word(32'd2);
      send_byte(8'h11); tick(); send_byte(8'h22); tick(); tick();
      send_byte(8'h33); send_byte(8'h44);
      chk("t5_w0_data", imem_wr_data, 32'h4433_2211);
      chk("t5_w0_en", {31'b0, imem_wr_en}, 32'd1);
      send_byte(8'h55); send_byte(8'h66);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_run", {29'b0, busy, cpu_reset, imem_wr_en}, 32'd0);
      chk("t5_addr", imem_addr, 32'h100);
      chk("t5_wr_data_clr", imem_wr_data, 32'd0);

      // start with a coincident byte: the byte must not enter the header
      start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
      tick();
      start = 1'b0; rx_valid = 1'b0;
      send_word(32'd1);
      chk("t5_hdr_skip", {30'b0, error, busy}, 32'd1);
      send_word(32'hDDCC_BBAA);
      chk("t5_sw_data", imem_wr_data, 32'hDDCC_BBAA);
      chk("t5_sw_addr", imem_addr, 32'h0);
      tick();
`ifdef CHECKSUM_EN
      send_word(32'hDDCC_BBAA);
`endif
      chk("t5_sw_done", {30'b0, done, cpu_reset}, 32'd2);

`ifdef CHECKSUM_EN
      // 6: bad checksum -> ERROR, never written
      tick();
      pulse_start();
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h0010_0093);
      tick();
      for (int k = 0; k < 4; k++) begin
         send_byte(8'h00);
         chk("t6_no_wr", {31'b0, imem_wr_en}, 32'd0);
      end
      chk("t6_error", {30'b0, error, done}, 32'd2);
      chk("t6_cpu_reset", {31'b0, cpu_reset}, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
